mrd_ctrl_fsm: RTL and testbench

MRD_CTRL_FSM -- requirements
Module: mrd_ctrl_fsm

---
 rtl/mrd_pkg.sv | 9 +
 rtl/mrd_cfg_check.sv | 26 ++
 rtl/mrd_ctrl_fsm.sv | 85 ++++++++
 tb/tb_mrd_ctrl_fsm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_pkg.sv
// mrd_pkg: shared state encoding, stage limit and legal radix set for the mixed-radix DFT controller
package mrd_pkg;
  localparam int DEF_MAX_STAGES = 6;
  localparam int PROD_W = 18;
  typedef enum logic [1:0] {SINK = 2'b00, COMPUTE = 2'b01, SOURCE = 2'b10, GAP = 2'b11} state_t;
  function automatic logic legal_radix(input logic [2:0] r);
    return r >= 3'd2 && r <= 3'd5;
  endfunction
endpackage

// File: rtl/mrd_cfg_check.sv
// mrd_cfg_check: combinational frame configuration validator (stage count, radix set, radix product)
module mrd_cfg_check
  import mrd_pkg::*;
#(
  parameter int MAX_STAGES = DEF_MAX_STAGES,
  parameter int W_PTS = 12
) (
  input  logic [W_PTS-1:0]        dftpts,
  input  logic [MAX_STAGES*3-1:0] nf,
  input  logic [2:0]              num_stages,
  output logic                    cfg_ok
);
  logic [PROD_W-1:0] prod;
  logic radix_ok;
  // Unused stages contribute a factor of 1 and are not radix-checked
  always_comb begin
    prod = PROD_W'(1);
    radix_ok = 1'b1;
    for (int i = 0; i < MAX_STAGES; i++)
      if (i < int'(num_stages)) begin
        prod = PROD_W'(prod * PROD_W'(nf[3*i+:3]));
        radix_ok = radix_ok & legal_radix(nf[3*i+:3]);
      end
    cfg_ok = radix_ok && num_stages != 3'd0 && int'(num_stages) <= MAX_STAGES && prod == PROD_W'(dftpts);
  end
endmodule

// File: rtl/mrd_ctrl_fsm.sv
// mrd_ctrl_fsm: frame controller sequencing SINK -> COMPUTE/GAP per factor stage -> SOURCE
module mrd_ctrl_fsm
  import mrd_pkg::*;
#(
  parameter int MAX_STAGES = DEF_MAX_STAGES,
  parameter int W_PTS = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sink_sop,
  input  logic [W_PTS-1:0]        dftpts_in,
  input  logic [MAX_STAGES*3-1:0] nf_in,
  input  logic [2:0]              num_stages_in,
  input  logic                    sink_ongoing,
  input  logic                    rd_ongoing,
  input  logic                    wr_ongoing,
  input  logic                    source_ongoing,
  output logic [1:0]              state,
  output logic [2:0]              current_stage,
  output logic [MAX_STAGES*3-1:0] nf,
  output logic [W_PTS-1:0]        dftpts,
  output logic                    frame_done,
  output logic                    cfg_err,
  output logic                    sop_drop
);
  state_t st, st_n;
  logic [2:0] nstg;
  logic [1:0] src_cnt;
  logic armed, seen_rd, sink_q, src_seen, cfg_ok, go, cdone, last, sdone;

  mrd_cfg_check #(.MAX_STAGES(MAX_STAGES), .W_PTS(W_PTS)) u_chk (
    .dftpts    (dftpts_in),
    .nf        (nf_in),
    .num_stages(num_stages_in),
    .cfg_ok    (cfg_ok)
  );

  assign state = st;
  // A sop landing on the sink_ongoing fall starts a new frame instead of launching the old one
  assign go = sink_q && !sink_ongoing && armed && !sink_sop;
  assign cdone = seen_rd && !rd_ongoing && !wr_ongoing;
  assign last = current_stage == nstg - 3'd1;
  assign sdone = !source_ongoing && (src_seen || src_cnt == 2'd3);

  always_comb begin
    st_n = st;
    st_n = st == SINK ? (go ? COMPUTE : SINK) :
           st == COMPUTE ? (cdone ? (last ? SOURCE : GAP) : COMPUTE) :
           st == GAP ? COMPUTE : (sdone ? SINK : SOURCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= SINK;
      current_stage <= '0;
      nf <= '0;
      dftpts <= '0;
      nstg <= '0;
      armed <= 1'b0;
      seen_rd <= 1'b0;
      sink_q <= 1'b0;
      src_seen <= 1'b0;
      src_cnt <= '0;
      frame_done <= 1'b0;
      cfg_err <= 1'b0;
      sop_drop <= 1'b0;
    end else begin
      st <= st_n;
      sink_q <= sink_ongoing;
      frame_done <= st == SOURCE && st_n == SINK;
      cfg_err <= st == SINK && sink_sop && !cfg_ok;
      sop_drop <= st != SINK && sink_sop;
      seen_rd <= st == COMPUTE && st_n == COMPUTE && (seen_rd || rd_ongoing);
      src_seen <= st == SOURCE && st_n == SOURCE && (src_seen || source_ongoing);
      src_cnt <= (st == SOURCE && st_n == SOURCE) ? src_cnt + 2'd1 : 2'd0;
      current_stage <= st == GAP ? current_stage + 3'd1 : (st_n == SINK ? 3'd0 : current_stage);
      if (st == SINK && sink_sop) begin
        nf <= nf_in;
        dftpts <= dftpts_in;
        nstg <= num_stages_in;
        armed <= cfg_ok;
      end else if (st_n == COMPUTE) armed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mrd_ctrl_fsm.sv
// tb_mrd_ctrl_fsm: table vectors, directed corner sequences and randomized frames vs a behavioural model
module tb_mrd_ctrl_fsm;
  logic clk = 0, rst_n = 1, sink_sop = 0;
  logic [11:0] dftpts_in = 0;
  logic [17:0] nf_in = 0;
  logic [2:0] num_stages_in = 0;
  logic sink_ongoing = 0, rd_ongoing = 0, wr_ongoing = 0, source_ongoing = 0;
  logic [1:0] state;
  logic [2:0] current_stage;
  logic [17:0] nf;
  logic [11:0] dftpts;
  logic frame_done, cfg_err, sop_drop;
  int total = 0, bad = 0, gaps = 0, dones = 0;

  typedef struct {int d; logic [17:0] n; int s; bit ok;} vec_t;
  vec_t tv[12];

  always #5 clk = ~clk;

  mrd_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .sink_sop(sink_sop), .dftpts_in(dftpts_in), .nf_in(nf_in),
    .num_stages_in(num_stages_in), .sink_ongoing(sink_ongoing), .rd_ongoing(rd_ongoing),
    .wr_ongoing(wr_ongoing), .source_ongoing(source_ongoing), .state(state),
    .current_stage(current_stage), .nf(nf), .dftpts(dftpts), .frame_done(frame_done),
    .cfg_err(cfg_err), .sop_drop(sop_drop)
  );

  always @(negedge clk) begin
    if (state == 2'b11) gaps++;
    if (frame_done) dones++;
  end

  function automatic logic [17:0] pk(input int a, input int b, input int c, input int d, input int e, input int f);
    return {f[2:0], e[2:0], d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  // Reference: accept iff 1..6 stages, all used radices in 2..5, and their product equals the length
  function automatic bit ref_ok(input int d, input logic [17:0] n, input int ns);
    int p, r;
    if (ns < 1 || ns > 6) return 0;
    p = 1;
    for (int i = 0; i < ns; i++) begin
      r = int'(n[3*i+:3]);
      if (r < 2 || r > 5) return 0;
      p = p * r;
    end
    return p == d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int d, input logic [17:0] n, input int s);
    sink_sop = 1; dftpts_in = 12'(d); nf_in = n; num_stages_in = 3'(s);
    tick();
    sink_sop = 0;
  endtask

  task automatic fall();
    sink_ongoing = 1;
    tick();
    sink_ongoing = 0;
    tick();
  endtask

  task automatic run_stage(input int idle, input int rl, input int wl);
    repeat (idle) tick();
    chk("compute_wait", state, 1);
    rd_ongoing = 1;
    repeat (rl) tick();
    rd_ongoing = 0; wr_ongoing = 1;
    repeat (wl) tick();
    wr_ongoing = 0;
    tick();
  endtask

  task automatic run_frame(input int ns, input bit stall);
    int g0;
    g0 = gaps;
    for (int s = 0; s < ns; s++) begin
      chk("compute_state", state, 1);
      chk("stage_idx", current_stage, s);
      run_stage($urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
      if (s < ns - 1) begin
        chk("gap_state", state, 3);
        tick();
      end else chk("source_state", state, 2);
    end
    chk("source_stage", current_stage, ns - 1);
    if (stall) begin
      repeat (3) tick();
      chk("stall_source", state, 2);
      tick();
    end else begin
      source_ongoing = 1;
      repeat ($urandom_range(1, 3)) tick();
      source_ongoing = 0;
      tick();
    end
    chk("end_sink", state, 0);
    chk("frame_done", frame_done, 1);
    chk("end_stage", current_stage, 0);
    tick();
    chk("done_pulse", frame_done, 0);
    chk("gap_count", gaps - g0, ns - 1);
  endtask

  initial begin
    int ns, dft, m, k, d0;
    int r[6];
    logic [17:0] n;
    bit ok;
    tv[0]  = '{12, pk(3,4,0,0,0,0), 2, 1};
    tv[1]  = '{12, pk(3,5,0,0,0,0), 2, 0};
    tv[2]  = '{6, pk(2,3,7,7,7,7), 2, 1};
    tv[3]  = '{2, pk(2,0,0,0,0,0), 0, 0};
    tv[4]  = '{64, pk(2,2,2,2,2,2), 7, 0};
    tv[5]  = '{64, pk(2,2,2,2,2,2), 6, 1};
    tv[6]  = '{6, pk(6,0,0,0,0,0), 1, 0};
    tv[7]  = '{1, pk(1,0,0,0,0,0), 1, 0};
    tv[8]  = '{1200, pk(5,5,4,4,3,0), 5, 1};
    tv[9]  = '{3401, pk(5,5,5,5,5,5), 6, 0};
    tv[10] = '{3125, pk(5,5,5,5,5,0), 5, 1};
    tv[11] = '{0, pk(0,0,0,0,0,0), 1, 0};

    #1 rst_n = 0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_stage", current_stage, 0);
    chk("rst_nf", int'(nf), 0);
    chk("rst_dftpts", dftpts, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sop_drop", sop_drop, 0);
    tick();
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      load(tv[i].d, tv[i].n, tv[i].s);
      chk($sformatf("tv%0d_cfg_err", i), cfg_err, !tv[i].ok);
      chk($sformatf("tv%0d_dftpts", i), dftpts, tv[i].d);
      chk($sformatf("tv%0d_nf", i), int'(nf), int'(tv[i].n));
      tick();
      chk($sformatf("tv%0d_err_pulse", i), cfg_err, 0);
    end
    rst_n = 0;
    tick();
    rst_n = 1;

    load(12, pk(3,4,0,0,0,0), 2);
    fall();
    run_frame(2, 0);
    fall();
    chk("disarmed_after_frame", state, 0);

    load(12, pk(3,5,0,0,0,0), 2);
    chk("bad_cfg_err", cfg_err, 1);
    tick();
    chk("bad_cfg_err_pulse", cfg_err, 0);
    fall();
    chk("bad_cfg_stay_sink", state, 0);

    load(12, pk(3,4,0,0,0,0), 2);
    fall();
    sink_sop = 1; dftpts_in = 12'd5; nf_in = pk(5,0,0,0,0,0); num_stages_in = 3'd1;
    tick();
    sink_sop = 0;
    chk("sop_drop", sop_drop, 1);
    chk("drop_dftpts", dftpts, 12);
    chk("drop_nf", int'(nf), int'(pk(3,4,0,0,0,0)));
    tick();
    chk("sop_drop_pulse", sop_drop, 0);
    run_frame(2, 1);

    load(12, pk(3,4,0,0,0,0), 2);
    fall();
    run_stage(0, 1, 0);
    chk("rst_mid_gap", state, 3);
    tick();
    chk("rst_mid_stage1", current_stage, 1);
    rd_ongoing = 1;
    #2 rst_n = 0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_stage", current_stage, 0);
    d0 = dones;
    tick();
    rst_n = 1; rd_ongoing = 0;
    repeat (6) tick();
    chk("no_done_after_rst", dones - d0, 0);
    chk("rst_nf_clear", int'(nf), 0);

    load(1200, pk(5,5,4,4,3,0), 5);
    chk("1200_ok", cfg_err, 0);
    fall();
    run_frame(5, 0);

    load(6, pk(2,3,0,0,0,0), 2);
    sink_ongoing = 1;
    tick();
    sink_ongoing = 0; sink_sop = 1; dftpts_in = 12'd20; nf_in = pk(4,5,0,0,0,0); num_stages_in = 3'd2;
    tick();
    sink_sop = 0;
    chk("coincident_stay_sink", state, 0);
    chk("coincident_latch", dftpts, 20);
    fall();
    run_frame(2, 0);

    load(6, pk(2,3,0,0,0,0), 2);
    load(60, pk(3,4,5,0,0,0), 3);
    chk("overwrite_dftpts", dftpts, 60);
    fall();
    run_frame(3, 1);

    repeat (40) begin
      ns = $urandom_range(1, 6);
      dft = 1;
      for (int i = 0; i < 6; i++) begin
        r[i] = (i < ns) ? int'($urandom_range(2, 5)) : int'($urandom_range(0, 7));
        if (i < ns) dft = dft * r[i];
      end
      m = $urandom_range(0, 3);
      if (m == 1) dft = dft ^ (1 << $urandom_range(0, 11));
      if (m == 2) begin
        k = $urandom_range(0, ns - 1);
        r[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(6, 7));
      end
      if (m == 3) ns = ($urandom_range(0, 1) == 1) ? 0 : 7;
      dft = dft & 12'hfff;
      n = pk(r[0], r[1], r[2], r[3], r[4], r[5]);
      ok = ref_ok(dft, n, ns);
      load(dft, n, ns);
      chk("rnd_cfg_err", cfg_err, !ok);
      chk("rnd_dftpts", dftpts, dft);
      chk("rnd_nf", int'(nf), int'(n));
      fall();
      if (ok) run_frame(ns, 1'($urandom_range(0, 1)));
      else chk("rnd_reject_sink", state, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
